morty_pipeline_ctrl: RTL
========================

Name: morty_pipeline_ctrl

Overview:
- Acts on the stall requests raised by the hazard detector (illegal, csr, load, xcall/break). Turns them, plus branch redirects and memory back-pressure, into per-stage stall and flush controls for the 5-stage pipeline.
- Owns the exception drain/trap sequence: fetch stops, older instructions retire, and a one-cycle trap-take pulse is issued to the CSR/PC logic.
- Sits between the hazard detector, the EX branch unit, the memory ports and every pipeline register.

Parameters:
- DRAIN_MAX, 4, maximum cycles spent in DRAIN waiting for the faulting instruction to reach MEM before a forced trap.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- illegal_stall_req_i  in  1  illegal instruction in ID/EX/MEM
- csr_stall_req_i  in  1  CSR read-after-write hazard
- ld_stall_req_i  in  1  load-use hazard
- xcall_break_stall_req_i  in  1  ecall/ebreak in ID/EX/MEM
- branch_taken_i  in  1  EX resolved a taken branch or jump
- mem_exception_i  in  1  faulting instruction is in MEM (commit point)
- imem_ready_i  in  1  instruction memory response valid
- dmem_ready_i  in  1  data memory not busy
- pc_stall_o  out  1  hold PC
- if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_stall_o  out  1 each  hold the named pipeline register
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  load a bubble into the named register
- trap_take_o  out  1  one-cycle pulse; CSR unit writes mepc/mcause and PC redirects to mtvec
- drain_timeout_o  out  1  sticky; DRAIN exited by timeout
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o high, wraps to 0 past all-ones

Behaviour:
- Reset (rst_i sampled high at posedge):
  - state=RUN, drain counter=0, stall_cnt_o=0, drain_timeout_o=0, trap_take_o=0.
  - While rst_i is high, all stall and flush outputs are 0.
  - Reset mid-DRAIN or in TRAP aborts the sequence; no trap_take_o is issued.
- State and counters are registered. Stall and flush outputs are combinational from the current state and inputs, so they act in the same cycle. trap_take_o is high exactly while state==TRAP.
- Priority, highest first:
  - 1. Memory back-pressure: dmem_ready_i=0 asserts all stalls and no flushes; the state machine holds, including the drain counter.
  - 2. Fetch wait: imem_ready_i=0 while in RUN asserts pc_stall_o and if_id_flush_o only.
  - 3. State-specific behaviour, below.
- RUN:
  - illegal or xcall request: go to DRAIN. In this cycle assert pc_stall_o and if_id_flush_o. A simultaneous branch_taken_i is ignored, because the faulting instruction is older.
  - Otherwise branch_taken_i: assert if_id_flush_o and id_ex_flush_o. No PC stall; the PC takes the target.
  - Otherwise csr or ld request: assert pc_stall_o, if_id_stall_o and id_ex_flush_o (bubble). Stay in RUN; the condition re-evaluates every cycle.
- DRAIN:
  - pc_stall_o=1 and if_id_flush_o=1 every cycle. ID/EX and later stages advance.
  - The counter increments each non-frozen cycle.
  - mem_exception_i=1: go to TRAP, counter cleared.
  - Counter==DRAIN_MAX-1 with no mem_exception_i: go to TRAP and set drain_timeout_o.
  - Hazard and branch requests are ignored.
- TRAP (exactly 1 cycle unless frozen by dmem):
  - trap_take_o=1.
  - if_id_flush_o, id_ex_flush_o and ex_mem_flush_o are all 1; pc_stall_o=0 so the PC loads mtvec.
  - Next state is RUN.
- stall_cnt_o increments on every cycle with pc_stall_o=1, including dmem freezes.
- drain_timeout_o is cleared only by reset.

Decomposition:
- morty_pkg holds:
  - the state enum (RUN=2'd0, DRAIN=2'd1, TRAP=2'd2)
  - the control bundle field order
  - the DRAIN_MAX default.
- One sub-module, morty_drain_counter: saturating up-counter with clear, hold and terminal-count outputs. Everything else lives in the top module.

Test Plan:
- ld_stall_req_i=1 for 1 cycle in RUN -> pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 that cycle; stall_cnt_o goes 0→1; state stays RUN.
- branch_taken_i=1 together with csr_stall_req_i=1 -> if_id_flush_o=1, id_ex_flush_o=1, pc_stall_o=0; stall_cnt_o unchanged.
- xcall_break_stall_req_i=1, then mem_exception_i=1 two cycles later -> DRAIN for 2 cycles, then trap_take_o=1 for exactly 1 cycle with all three flushes high; back to RUN; drain_timeout_o=0.
- illegal_stall_req_i=1 and mem_exception_i never asserted, DRAIN_MAX=4 -> trap_take_o pulses on the 5th cycle after entry; drain_timeout_o=1 and stays 1.
- dmem_ready_i=0 for 3 cycles during DRAIN -> all stalls high, no flushes; trap arrives 3 cycles later than in the unfrozen case; stall_cnt_o increases by 3 extra.
- rst_i=1 while in TRAP -> next cycle trap_take_o=0, state RUN, stall_cnt_o=0, all outputs 0.

Source files
------------

// File: rtl/morty_pkg.sv
// ============================================================================
// Module      : morty_pkg
// Description : Shared types and constants for the pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morty_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } state_e;

    // Field order is the canonical ordering of the per-stage control bundle.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic mem_wb_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    localparam int    C_DRAIN_MAX_DEFAULT = 4;
    localparam ctrl_t C_CTRL_FREEZE       = ctrl_t'(8'b1111_1000);

endpackage

`default_nettype wire

// File: rtl/morty_pipeline_ctrl_if.sv
// ============================================================================
// Module      : morty_pipeline_ctrl_if
// Description : Hazard, redirect, memory-ready and stage-control signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface morty_pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             illegal_stall_req_i;
    logic             csr_stall_req_i;
    logic             ld_stall_req_i;
    logic             xcall_break_stall_req_i;
    logic             branch_taken_i;
    logic             mem_exception_i;
    logic             imem_ready_i;
    logic             dmem_ready_i;
    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             id_ex_stall_o;
    logic             ex_mem_stall_o;
    logic             mem_wb_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             ex_mem_flush_o;
    logic             trap_take_o;
    logic             drain_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output illegal_stall_req_i, csr_stall_req_i, ld_stall_req_i,
               xcall_break_stall_req_i, branch_taken_i, mem_exception_i,
               imem_ready_i, dmem_ready_i,
        input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
               trap_take_o, drain_timeout_o, stall_cnt_o
    );

    modport slave (
        input  illegal_stall_req_i, csr_stall_req_i, ld_stall_req_i,
               xcall_break_stall_req_i, branch_taken_i, mem_exception_i,
               imem_ready_i, dmem_ready_i,
        output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
               trap_take_o, drain_timeout_o, stall_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/morty_drain_counter.sv
// ============================================================================
// Module      : morty_drain_counter
// Description : Saturating up-counter with clear, hold and terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morty_drain_counter #(
    parameter int MAX = 4
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic clr_i,
    input  wire logic inc_i,
    output logic      tc_o
);
    localparam int           W    = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] C_TC = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; the count parks at terminal rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != C_TC)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == C_TC);

endmodule

`default_nettype wire

// File: rtl/morty_pipeline_ctrl.sv
// ============================================================================
// Module      : morty_pipeline_ctrl
// Description : Per-stage stall/flush generation and exception drain/trap FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morty_pipeline_ctrl
    import morty_pkg::*;
#(
    parameter int DRAIN_MAX = C_DRAIN_MAX_DEFAULT,
    parameter int CNT_W     = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    morty_pipeline_ctrl_if.slave   bus
);
    state_e           state_q, state_d;
    logic             drain_timeout_q, drain_timeout_d;
    logic             trap_take_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    ctrl_t            ctrl;
    logic             frozen;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;

    morty_drain_counter #(
        .MAX (DRAIN_MAX)
    ) u_drain_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        frozen          = !bus.dmem_ready_i;
        ctrl            = '0;
        state_d         = state_q;
        drain_timeout_d = drain_timeout_q;
        cnt_clr         = (state_q != DRAIN);
        cnt_inc         = 1'b0;

        if (frozen) begin
            ctrl = C_CTRL_FREEZE;
        end else if ((state_q == RUN) && !bus.imem_ready_i) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    // The faulting instruction is older than any branch in EX.
                    if (bus.illegal_stall_req_i || bus.xcall_break_stall_req_i) begin
                        state_d          = DRAIN;
                        ctrl.pc_stall    = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                    end else if (bus.branch_taken_i) begin
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (bus.csr_stall_req_i || bus.ld_stall_req_i) begin
                        ctrl.pc_stall    = 1'b1;
                        ctrl.if_id_stall = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                    cnt_inc          = 1'b1;
                    if (bus.mem_exception_i) begin
                        state_d = TRAP;
                        cnt_clr = 1'b1;
                    end else if (cnt_tc) begin
                        state_d         = TRAP;
                        cnt_clr         = 1'b1;
                        drain_timeout_d = 1'b1;
                    end
                end
                TRAP: begin
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_ex_flush  = 1'b1;
                    ctrl.ex_mem_flush = 1'b1;
                    state_d           = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        if (rst_i) begin
            ctrl = '0;
        end

        stall_cnt_d = stall_cnt_q + CNT_W'(ctrl.pc_stall);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= RUN;
            drain_timeout_q <= 1'b0;
            trap_take_q     <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            drain_timeout_q <= drain_timeout_d;
            trap_take_q     <= (state_d == TRAP);
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign bus.pc_stall_o      = ctrl.pc_stall;
    assign bus.if_id_stall_o   = ctrl.if_id_stall;
    assign bus.id_ex_stall_o   = ctrl.id_ex_stall;
    assign bus.ex_mem_stall_o  = ctrl.ex_mem_stall;
    assign bus.mem_wb_stall_o  = ctrl.mem_wb_stall;
    assign bus.if_id_flush_o   = ctrl.if_id_flush;
    assign bus.id_ex_flush_o   = ctrl.id_ex_flush;
    assign bus.ex_mem_flush_o  = ctrl.ex_mem_flush;
    assign bus.trap_take_o     = trap_take_q;
    assign bus.drain_timeout_o = drain_timeout_q;
    assign bus.stall_cnt_o     = stall_cnt_q;

endmodule

`default_nettype wire
